// File: rtl/accel_stream_dispatch.sv
// accel_stream_dispatch
//   Routes an upstream AXI-Stream to one of NUM_KERN kernels (one-hot select
//   latched at start), collects that kernel's result words into a
//   first-word-fall-through FIFO and returns exactly result_len words
//   downstream, marking the final word with m_tlast.
//
// Optional feature: define ACC_DISPATCH_ERR_EN to build the sticky illegal
//   start / discarded-word error flag; without it err is tied low.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   ap_start/result_len one-hot kernel start and result length (IDLE only)
//   ap_idle/ap_done/err status
//   s_*                upstream stream from DMA
//   k_*                per-kernel input streams (k_tdata shared)
//   r_valid/r_data/r_ready kernel result push
//   k_done             kernel completion
//   m_*                downstream result stream to DMA
module accel_stream_dispatch #(
  parameter int DATA_W     = 32,
  parameter int NUM_KERN   = 3,
  parameter int FIFO_DEPTH = 64,
  parameter int LEN_W      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_KERN-1:0]        ap_start,
  input  logic [LEN_W-1:0]           result_len,
  output logic                       ap_idle,
  output logic [NUM_KERN-1:0]        ap_done,
  output logic                       err,
  input  logic                       s_tvalid,
  input  logic [DATA_W-1:0]          s_tdata,
  input  logic                       s_tlast,
  output logic                       s_tready,
  output logic [NUM_KERN-1:0]        k_tvalid,
  output logic [DATA_W-1:0]          k_tdata,
  output logic [NUM_KERN-1:0]        k_tlast,
  input  logic [NUM_KERN-1:0]        k_tready,
  input  logic [NUM_KERN-1:0]        r_valid,
  input  logic [NUM_KERN*DATA_W-1:0] r_data,
  output logic [NUM_KERN-1:0]        r_ready,
  input  logic [NUM_KERN-1:0]        k_done,
  output logic                       m_tvalid,
  output logic [DATA_W-1:0]          m_tdata,
  output logic                       m_tlast,
  input  logic                       m_tready
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [NUM_KERN-1:0] K_ONE   = 1;
  localparam logic [LEN_W-1:0]    LEN_ONE = 1;
  localparam logic [AW-1:0]       PTR_ONE = 1;
  localparam logic [AW:0]         CNT_ONE = 1;

  logic [1:0]          state_q, state_d;
  logic [NUM_KERN-1:0] sel_q, sel_d;
  logic [LEN_W-1:0]    remain_q, remain_d;
  logic [LEN_W-1:0]    acc_q, acc_d;     // words written into the FIFO this run
  logic [LEN_W-1:0]    sent_q, sent_d;   // words popped downstream this run
  logic [AW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

  logic                run, active, full, start_ok, done_hit;
  logic                push_hs, wr, pop, last_beat;
  logic [DATA_W-1:0]   rdata_sel;

  assign run      = (state_q == S_RUN);
  assign active   = run || (state_q == S_DRAIN);
  assign full     = (32'(cnt_q) == FIFO_DEPTH);
  assign start_ok = (ap_start != '0) && ((ap_start & (ap_start - K_ONE)) == '0);
  assign done_hit = run && ((k_done & sel_q) != '0);

  // Input routing is purely combinational while running.
  assign k_tvalid = run ? (sel_q & {NUM_KERN{s_tvalid}}) : '0;
  assign k_tlast  = run ? (sel_q & {NUM_KERN{s_tlast}})  : '0;
  assign k_tdata  = run ? s_tdata : '0;
  assign s_tready = run && ((k_tready & sel_q) != '0);

  assign r_ready  = (active && !full) ? sel_q : '0;
  assign push_hs  = ((r_valid & r_ready) != '0);
  // Words past result_len are still handshaken so the kernel never stalls.
  assign wr       = push_hs && (acc_q < remain_q);

  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < NUM_KERN; i++) begin
      if (sel_q[i]) rdata_sel = r_data[i*DATA_W +: DATA_W];
    end
  end

  assign m_tvalid  = active && (cnt_q != '0);
  assign m_tdata   = active ? mem_q[rptr_q] : '0;
  assign last_beat = (sent_q == remain_q - LEN_ONE);
  assign m_tlast   = m_tvalid && last_beat;
  assign pop       = m_tvalid && m_tready;

  assign ap_idle   = (state_q == S_IDLE);
  assign ap_done   = done_hit ? sel_q : '0;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    remain_d = remain_q;
    acc_d    = acc_q;
    sent_d   = sent_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    cnt_d    = cnt_q;
    if (wr) begin
      wptr_d = wptr_q + PTR_ONE;
      acc_d  = acc_q + LEN_ONE;
    end
    if (pop) begin
      rptr_d = rptr_q + PTR_ONE;
      sent_d = sent_q + LEN_ONE;
    end
    case ({wr, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d  = S_RUN;
          sel_d    = ap_start;
          remain_d = result_len;
          acc_d    = '0;
          sent_d   = '0;
        end
      end
      S_RUN: begin
        if (done_hit) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // sent==remain also covers remain==0 and a final pop that already
        // happened in the same cycle as k_done.
        if ((sent_q == remain_q) || (pop && last_beat)) begin
          state_d = S_IDLE;
          wptr_d  = '0;
          rptr_d  = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        wptr_d  = '0;
        rptr_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      remain_q <= '0;
      acc_q    <= '0;
      sent_q   <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      remain_q <= remain_d;
      acc_q    <= acc_d;
      sent_q   <= sent_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q] <= rdata_sel;
  end

`ifdef ACC_DISPATCH_ERR_EN
  logic err_q;
  // acc_q equals sent+count during a run, so a push rejected by the length
  // limit is exactly a discarded word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state_q == S_IDLE) begin
      if (start_ok)              err_q <= 1'b0;
      else if (ap_start != '0)   err_q <= 1'b1;
    end else if (push_hs && !wr) begin
      err_q <= 1'b1;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_accel_stream_dispatch.sv
module tb_accel_stream_dispatch;
  localparam int DW = 32;
  localparam int NK = 3;
  localparam int FD = 64;
  localparam int LW = 8;

`ifdef ACC_DISPATCH_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NK-1:0]     ap_start;
  logic [LW-1:0]     result_len;
  logic              ap_idle;
  logic [NK-1:0]     ap_done;
  logic              err;
  logic              s_tvalid;
  logic [DW-1:0]     s_tdata;
  logic              s_tlast;
  logic              s_tready;
  logic [NK-1:0]     k_tvalid;
  logic [DW-1:0]     k_tdata;
  logic [NK-1:0]     k_tlast;
  logic [NK-1:0]     k_tready;
  logic [NK-1:0]     r_valid;
  logic [NK*DW-1:0]  r_data;
  logic [NK-1:0]     r_ready;
  logic [NK-1:0]     k_done;
  logic              m_tvalid;
  logic [DW-1:0]     m_tdata;
  logic              m_tlast;
  logic              m_tready;

  always #5 clk = ~clk;

  accel_stream_dispatch #(.DATA_W(DW), .NUM_KERN(NK), .FIFO_DEPTH(FD), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .ap_start(ap_start), .result_len(result_len),
    .ap_idle(ap_idle), .ap_done(ap_done), .err(err),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tready(s_tready),
    .k_tvalid(k_tvalid), .k_tdata(k_tdata), .k_tlast(k_tlast), .k_tready(k_tready),
    .r_valid(r_valid), .r_data(r_data), .r_ready(r_ready), .k_done(k_done),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t         sb[$];
  beat_t         mon_e;
  int            checks = 0;
  int            errors = 0;
  int            beats, lasts, done_cnt;
  logic [NK-1:0] done_val;
  int            rdy_mode = 0;
  int            rdy_ph = 0;
  logic          hold_pend = 1'b0;
  logic [DW-1:0] hold_d;
  logic          hold_l;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor / scoreboard checker
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (ap_done != '0) begin
        done_cnt++;
        done_val = ap_done;
      end
      if (hold_pend) begin
        chk("hold_valid", 64'(m_tvalid), 64'd1);
        chk("hold_data", 64'(m_tdata), 64'(hold_d));
        chk("hold_last", 64'(m_tlast), 64'(hold_l));
      end
      hold_pend = 1'b0;
      if (m_tvalid) begin
        if (m_tready) begin
          beats++;
          if (m_tlast) lasts++;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_beat actual=%0h required=none", m_tdata);
          end else begin
            mon_e = sb.pop_front();
            chk("beat_data", 64'(m_tdata), 64'(mon_e.d));
            chk("beat_last", 64'(m_tlast), 64'(mon_e.l));
          end
        end else begin
          hold_pend = 1'b1;
          hold_d    = m_tdata;
          hold_l    = m_tlast;
        end
      end
    end
  end

  // Downstream ready pattern: 0 always ready, 1 ready one cycle in three, 2 stalled
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: m_tready = 1'b1;
      1: begin
        m_tready = (rdy_ph == 0);
        rdy_ph   = (rdy_ph + 1) % 3;
      end
      default: m_tready = 1'b0;
    endcase
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [NK-1:0] v, input logic [LW-1:0] len);
    beats = 0; lasts = 0; done_cnt = 0; done_val = '0;
    ap_start   = v;
    result_len = len;
    cyc(1);
    ap_start = '0;
  endtask

  task automatic kpush(input int k, input logic [DW-1:0] d, input logic keep, input logic last);
    logic hs;
    int   t;
    hs = 1'b0;
    t  = 0;
    r_valid[k] = 1'b1;
    r_data[k*DW +: DW] = d;
    while (!hs) begin
      @(negedge clk);
      hs = r_ready[k];
      @(posedge clk);
      #1;
      t++;
      if (!hs && t > 400) begin
        checks++;
        errors++;
        $display("FAIL push_timeout actual=no_ready required=ready kernel=%0d", k);
        break;
      end
    end
    if (hs && keep) sb.push_back('{d: d, l: last});
    r_valid[k] = 1'b0;
  endtask

  task automatic kburst(input int k, input int n, input int keep_n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) kpush(k, base + DW'(i), (i < keep_n), (i == keep_n - 1));
  endtask

  task automatic kdone(input int k);
    k_done[k] = 1'b1;
    cyc(1);
    k_done[k] = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int t;
    t = 0;
    while (1) begin
      @(negedge clk);
      if (ap_idle) break;
      t++;
      if (t > limit) begin
        checks++;
        errors++;
        $display("FAIL idle_timeout actual=busy required=idle");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic end_checks(input int nbeats, input logic [NK-1:0] dv);
    chk("beat_count", 64'(beats), 64'(nbeats));
    chk("tlast_count", 64'(lasts), 64'd1);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("done_value", 64'(done_val), 64'(dv));
  endtask

  initial begin
    rst = 1'b1;
    ap_start = '0; result_len = '0;
    s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
    k_tready = '0; r_valid = '0; r_data = '0; k_done = '0;
    m_tready = 1'b0;
    beats = 0; lasts = 0; done_cnt = 0; done_val = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_idle", 64'(ap_idle), 64'd1);
    chk("rst_mvalid", 64'(m_tvalid), 64'd0);
    chk("rst_rready", 64'(r_ready), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1);

    // Kernel 0, 64 words, always ready; plus combinational routing
    rdy_mode = 0;
    do_start(3'b001, 8'd64);
    s_tvalid = 1'b1; s_tdata = 32'hA5A5_0001; s_tlast = 1'b1; k_tready = 3'b001;
    #1;
    chk("run_idle", 64'(ap_idle), 64'd0);
    chk("route_kvalid", 64'(k_tvalid), 64'b001);
    chk("route_klast", 64'(k_tlast), 64'b001);
    chk("route_kdata", 64'(k_tdata), 64'hA5A5_0001);
    chk("route_sready", 64'(s_tready), 64'd1);
    chk("route_rready", 64'(r_ready), 64'b001);
    k_tready = 3'b010;
    #1;
    chk("route_sready_other", 64'(s_tready), 64'd0);
    s_tvalid = 1'b0; s_tlast = 1'b0; k_tready = '0;
    kburst(0, 64, 64, 32'h1000);
    kdone(0);
    wait_idle(500);
    end_checks(64, 3'b001);

    // Illegal start 3'b011
    ap_start = 3'b011;
    cyc(1);
    ap_start = '0;
    cyc(2);
    chk("bad_start_idle", 64'(ap_idle), 64'd1);
    chk("bad_start_err", 64'(err), 64'(EXP_ERR));
    chk("bad_start_rready", 64'(r_ready), 64'd0);

    // Kernel 1, 16 words, ready one cycle in three
    rdy_mode = 1;
    do_start(3'b010, 8'd16);
    chk("legal_start_clears_err", 64'(err), 64'd0);
    kburst(1, 16, 16, 32'h2000);
    kdone(1);
    wait_idle(1000);
    end_checks(16, 3'b010);

    // Kernel 0, 80 words with downstream stalled until FIFO fills
    rdy_mode = 2;
    do_start(3'b001, 8'd80);
    fork
      kburst(0, 80, 80, 32'h3000);
      begin
        cyc(10);
        chk("prefull_rready", 64'(r_ready), 64'b001);
        cyc(65);
        chk("full_rready", 64'(r_ready), 64'd0);
        chk("full_mvalid", 64'(m_tvalid), 64'd1);
        chk("full_no_beats", 64'(beats), 64'd0);
        rdy_mode = 0;
      end
    join
    kdone(0);
    wait_idle(500);
    end_checks(80, 3'b001);

    // Kernel 2, length 10 but 12 words pushed
    rdy_mode = 0;
    do_start(3'b100, 8'd10);
    kburst(2, 12, 10, 32'h4000);
    kdone(2);
    wait_idle(500);
    end_checks(10, 3'b100);
    chk("excess_err", 64'(err), 64'(EXP_ERR));

    // Reset in DRAIN with 5 words queued
    rdy_mode = 2;
    do_start(3'b001, 8'd10);
    kburst(0, 5, 5, 32'h5000);
    kdone(0);
    cyc(2);
    chk("drain_busy", 64'(ap_idle), 64'd0);
    chk("drain_mvalid", 64'(m_tvalid), 64'd1);
    s_tvalid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_idle", 64'(ap_idle), 64'd1);
    chk("mid_rst_done", 64'(ap_done), 64'd0);
    chk("mid_rst_err", 64'(err), 64'd0);
    chk("mid_rst_sready", 64'(s_tready), 64'd0);
    chk("mid_rst_kvalid", 64'(k_tvalid), 64'd0);
    chk("mid_rst_klast", 64'(k_tlast), 64'd0);
    chk("mid_rst_rready", 64'(r_ready), 64'd0);
    chk("mid_rst_mvalid", 64'(m_tvalid), 64'd0);
    chk("mid_rst_mlast", 64'(m_tlast), 64'd0);
    chk("mid_rst_mdata", 64'(m_tdata), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    s_tvalid = 1'b0;
    sb.delete();
    rdy_mode = 0;
    cyc(2);
    chk("post_rst_mvalid", 64'(m_tvalid), 64'd0);
    do_start(3'b001, 8'd4);
    kburst(0, 4, 4, 32'h6000);
    kdone(0);
    wait_idle(500);
    end_checks(4, 3'b001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/accel_stream_dispatch.md
# accel_stream_dispatch

Parametrised stream dispatcher for the user-project accelerator subsystem. It sits between the DMA AXI-Stream ports and NUM_KERN compute kernels (FIR, matmul, sorting, and future kernels). It routes input data to the one-hot selected kernel and collects that kernel's results into an internal output FIFO. It returns a result stream of programmable length with a proper AXI-Stream valid/ready hold and a `tlast` on the final word.

## Interface

Parameters:
- `DATA_W`, 32, stream and result word width.
- `NUM_KERN`, 3, number of attached kernels; bit i of every per-kernel vector is kernel i.
- `FIFO_DEPTH`, 64, output FIFO entries; power of two, all entries usable.
- `LEN_W`, 8, width of the result-length field.

Ports (clock and reset first):
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `ap_start` in NUM_KERN: one-hot kernel start request, sampled in IDLE only.
- `result_len` in LEN_W: number of result words to return, latched with start.
- `ap_idle` out 1: high in IDLE.
- `ap_done` out NUM_KERN: one-cycle pulse on the selected kernel's bit when its done is seen.
- `err` out 1: sticky illegal-start flag; see Configuration.
- `s_tvalid` in 1, `s_tdata` in DATA_W, `s_tlast` in 1, `s_tready` out 1: upstream stream from DMA.
- `k_tvalid` out NUM_KERN, `k_tdata` out DATA_W, `k_tlast` out NUM_KERN, `k_tready` in NUM_KERN: per-kernel input streams; `k_tdata` is shared.
- `r_valid` in NUM_KERN, `r_data` in NUM_KERN*DATA_W, `r_ready` out NUM_KERN: kernel result push; kernel i uses bits [i*DATA_W +: DATA_W].
- `k_done` in NUM_KERN: kernel completion level/pulse.
- `m_tvalid` out 1, `m_tdata` out DATA_W, `m_tlast` out 1, `m_tready` in 1: downstream stream to DMA.

## Operation

- States: IDLE, RUN, DRAIN. An encoding not in this set recovers to IDLE.
- **IDLE**
  - `ap_idle`=1; all stream ready/valid outputs are 0.
  - If `ap_start` is exactly one-hot: latch it into `sel`, latch `result_len` into `remain`, clear the word counter, go to RUN.
  - A zero or non-one-hot `ap_start` is ignored.
- **RUN**
  - `k_tvalid[sel]`=`s_tvalid` and `k_tlast[sel]`=`s_tlast`; the other kernels see 0.
  - `k_tdata`=`s_tdata`; `s_tready`=`k_tready[sel]`.
  - `r_ready[sel]`=~full; the other `r_ready` bits are 0.
  - A push occurs on `r_valid[sel]` & `r_ready[sel]`. It writes to the FIFO only while accepted words < `remain`. Excess words are handshaken and discarded.
  - On `k_done[sel]`: pulse `ap_done[sel]` for one cycle and go to DRAIN.
- **DRAIN**
  - `s_tready`=0 and `k_tvalid`=0.
  - The result push remains enabled, so a kernel may deliver late words.
- **Output (RUN and DRAIN)**
  - `m_tvalid`=~empty; `m_tdata`=FIFO head (first-word-fall-through).
  - A pop occurs on `m_tvalid` & `m_tready` and increments `sent`.
  - `m_tlast`=`m_tvalid` & (`sent`==`remain`-1).
- **Return to IDLE**
  - From DRAIN, go to IDLE when the last word is popped, or immediately if `remain`==0 (no output and no `tlast`).
  - Entering IDLE clears the FIFO pointers and count.
- Counters are LEN_W bits and never wrap: `sent` ≤ `remain`.
- The FIFO count is clog2(FIFO_DEPTH)+1 bits.

## Timing

- Reset values: `ap_idle`=1; `ap_done`=0, `err`=0, `s_tready`=0, `k_tvalid`=0, `k_tlast`=0, `r_ready`=0, `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0; state=IDLE; FIFO empty.
- IDLE→RUN takes 1 cycle after the start sample. Input routing is combinational in RUN.
- Push-to-`m_tvalid` latency is 1 cycle.
- `m_tvalid`, `m_tdata` and `m_tlast` are held stable while `m_tready`=0.
- Full: `r_ready`=0, computed from the registered count, so a push at full is impossible.
- Simultaneous push and pop when not full: the count is unchanged.
- `k_done` and the final pop in the same cycle: go to DRAIN, then exit to IDLE on the next evaluation.
- `rst` mid-operation returns immediately to reset values and discards FIFO contents. No `ap_done` is issued.
- `ap_start` changes outside IDLE are ignored.

## Configuration

- `ACC_DISPATCH_ERR_EN` defined:
  - A nonzero, non-one-hot `ap_start` in IDLE sets `err`.
  - A kernel result push while `sent`+FIFO count ≥ `remain` (discarded word) also sets `err`.
  - `err` is cleared only by the next legal start.
- `ACC_DISPATCH_ERR_EN` undefined: `err` is tied to 0 and no detection logic is built.

## Test plan

- Start=3'b001, `result_len`=64, kernel 0 returns 64 words with `m_tready`=1:
  - 64 beats in order; `m_tlast` only on beat 64; `ap_done`=3'b001 for one pulse; then back to IDLE.
- Start=3'b010, `result_len`=16, `m_tready` toggling 1-of-3 cycles:
  - No data loss or duplication; outputs held stable while stalled; exactly 16 beats.
- FIFO_DEPTH=64, `result_len`=80, `m_tready`=0 until the FIFO fills:
  - `r_ready[sel]`=0 at count 64; after `m_tready`=1, all 80 words arrive with `tlast` on word 80.
- Start=3'b100, `result_len`=10, kernel pushes 12 words:
  - 10 output beats; words 11-12 dropped; `err`=1 with `ACC_DISPATCH_ERR_EN` defined, 0 without.
- Start=3'b011 in IDLE:
  - Stays IDLE, `ap_idle`=1, `err` per macro.
- Assert `rst` mid-DRAIN with 5 words queued:
  - All outputs at reset values next cycle; a new start=3'b001 runs cleanly.
